// File: rtl/chunk_shifter_pkg.sv
// Shared helpers for the skew / de-skew stage pair.
// nchunks gives the lane count for a word split into CHUNK-bit lanes.
package chunk_shifter_pkg;

  function automatic int nchunks(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/chunk_shifter_delay.sv
// DELAY-deep register chain with synchronous clear and enable hold.
// DELAY=0 degenerates to a wire; the control inputs are then unused.
module delay #(
  parameter int DELAY = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (DELAY == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign out = in;
  end else begin : g_chain
    logic [WIDTH-1:0] chain_q [DELAY];
    logic [WIDTH-1:0] chain_d [DELAY];

    always_comb begin
      chain_d[0] = in;
      for (int k = 1; k < DELAY; k++) begin
        chain_d[k] = chain_q[k-1];
      end
    end

    // Reset wins over enable so a flush works even while stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DELAY; k++) begin
          chain_q[k] <= '0;
        end
      end else if (en) begin
        chain_q <= chain_d;
      end
    end

    assign out = chain_q[DELAY-1];
  end

endmodule

// File: rtl/chunk_shifter.sv
// Input skew stage: lane i of the word leaves i enabled cycles after entry.
// Lane 0 is combinational; the last lane may be narrower than CHUNK.
module chunk_shifter
  import chunk_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  localparam int N = nchunks(WIDTH, CHUNK);

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int LW = (i == N - 1) ? (WIDTH - (N - 1) * CHUNK) : CHUNK;

    delay #(
      .DELAY (i),
      .WIDTH (LW)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .in  (in[i*CHUNK +: LW]),
      .out (out[i*CHUNK +: LW])
    );
  end

endmodule

// File: tb/tb_chunk_shifter.sv
module tb_chunk_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] in8 = 8'h00;
  logic [7:0] out8;
  logic [6:0] in7 = 7'h00;
  logic [6:0] out7;
  logic [7:0] rt_out;
  logic [7:0] ref_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunk_shifter #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk (clk), .rst (rst), .en (en), .in (in8), .out (out8)
  );

  chunk_shifter #(.WIDTH(7), .CHUNK(3)) dut7 (
    .clk (clk), .rst (rst), .en (en), .in (in7), .out (out7)
  );

  // De-skew stage: lane i delayed by 3-i more cycles.
  for (genvar i = 0; i < 4; i++) begin : g_deskew
    delay #(.DELAY(3 - i), .WIDTH(2)) u_dsk (
      .clk (clk), .rst (rst), .en (en),
      .in  (out8[2*i +: 2]), .out (rt_out[2*i +: 2])
    );
  end

  delay #(.DELAY(3), .WIDTH(8)) u_ref (
    .clk (clk), .rst (rst), .en (en), .in (in8), .out (ref_out)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [25];

  // Words captured on enabled edges, newest first.
  logic [7:0] cap [3];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_skew(input logic [7:0] cur);
    logic [7:0] r;
    logic [7:0] src;
    for (int b = 0; b < 8; b++) begin
      src  = (b / 2 == 0) ? cur : cap[b/2 - 1];
      r[b] = src[b];
    end
    return r;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hE6, 8'h02};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'hFF, 8'h03};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h0C};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h30};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'hC0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'h03};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h0C};
    vecs[10] = '{1'b0, 1'b0, 8'h01, 8'h0D};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h0C};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 8'h0C};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h30};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 8'hC0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 8'hFF, 8'h03};
    vecs[17] = '{1'b1, 1'b1, 8'h00, 8'h0C};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[19] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[20] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[21] = '{1'b0, 1'b1, 8'hFF, 8'h03};
    vecs[22] = '{1'b1, 1'b0, 8'h00, 8'h0C};
    vecs[23] = '{1'b0, 1'b1, 8'h00, 8'h00};
    vecs[24] = '{1'b0, 1'b1, 8'h00, 8'h00};

    #1;
    rst = 1'b1;
    en  = 1'b1;
    in8 = 8'h00;
    tick();
    tick();

    for (int v = 0; v < 25; v++) begin
      rst = vecs[v].rst;
      en  = vecs[v].en;
      in8 = vecs[v].din;
      #1;
      check($sformatf("vec%0d", v), out8, vecs[v].exp);
      tick();
    end

    // Odd geometry: 7 bits in 3-bit lanes, last lane 1 bit.
    rst = 1'b0;
    en  = 1'b1;
    in8 = 8'h00;
    in7 = 7'h7F;
    #1;
    check("odd0", {1'b0, out7}, 8'h07);
    tick();
    in7 = 7'h00;
    #1;
    check("odd1", {1'b0, out7}, 8'h38);
    tick();
    #1;
    check("odd2", {1'b0, out7}, 8'h40);
    tick();
    #1;
    check("odd3", {1'b0, out7}, 8'h00);
    tick();

    // Random stream against the model, including stalls and resets.
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) cap[k] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      in8 = 8'($urandom);
      #1;
      check("skew", out8, model_skew(in8));
      check("roundtrip", rt_out, cap[2]);
      check("ref_delay", ref_out, cap[2]);
      tick();
      if (rst) begin
        for (int k = 0; k < 3; k++) cap[k] = 8'h00;
      end else if (en) begin
        cap[2] = cap[1];
        cap[1] = cap[0];
        cap[0] = in8;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
